// File: rtl/apb_master_arbiter_if.sv
// Request-side and APB-side signal bundle for apb_master_arbiter.
// master modport: the arbiter; slave modport: requesters, APB master and bus.
interface apb_master_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_rw;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        ack;
  logic [DATA_W-1:0]         rdata;
  logic [IDW-1:0]            grant_id;
  logic                      busy;

  logic                      m_transfer;
  logic                      m_read_write;
  logic [ADDR_W-1:0]         m_addr;
  logic [DATA_W-1:0]         m_wdata;

  logic                      psel;
  logic                      penable;
  logic                      pready;
  logic [DATA_W-1:0]         prdata;

  modport master (
    input  req,
    input  req_rw,
    input  req_addr,
    input  req_wdata,
    output ack,
    output rdata,
    output grant_id,
    output busy,
    output m_transfer,
    output m_read_write,
    output m_addr,
    output m_wdata,
    input  psel,
    input  penable,
    input  pready,
    input  prdata
  );

  modport slave (
    output req,
    output req_rw,
    output req_addr,
    output req_wdata,
    input  ack,
    input  rdata,
    input  grant_id,
    input  busy,
    input  m_transfer,
    input  m_read_write,
    input  m_addr,
    input  m_wdata,
    output psel,
    output penable,
    output pready,
    output prdata
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// Round-robin sharing of one APB master between NUM_REQ requesters.
// Define APB_ARB_FIXED_PRI_EN for fixed priority (lowest index wins).
module apb_master_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  apb_master_arbiter_if.master bus
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ACK_ONE = NUM_REQ'(1);
  localparam logic [IDW-1:0]     ID_LAST = IDW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_WAIT,
    ST_DONE
  } state_e;

  state_e              state_q;
  logic [NUM_REQ-1:0]  ack_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [IDW-1:0]      grant_q;
  logic [IDW-1:0]      ptr_q;
  logic                busy_q;
  logic                xfer_q;
  logic                rw_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;

  logic                win_vld;
  logic [IDW-1:0]      win_id;
  logic [IDW-1:0]      ptr_d;
  logic                setup_seen;
  logic                access_done;

  // Search starts at the pointer; in fixed-priority mode it stays 0.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = (int'(ptr_q) + k) % NUM_REQ;
      if (!win_vld && bus.req[j]) begin
        win_vld = 1'b1;
        win_id  = IDW'(j);
      end
    end
  end

  always_comb begin
    ptr_d = '0;
    if (grant_q != ID_LAST) begin
      ptr_d = grant_q + 1'b1;
    end
  end

  assign setup_seen  = bus.psel && !bus.penable;
  assign access_done = bus.psel && bus.penable && bus.pready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ack_q   <= '0;
      rdata_q <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      xfer_q  <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      ack_q <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (win_vld) begin
            state_q <= ST_GRANT;
            grant_q <= win_id;
            rw_q    <= bus.req_rw[win_id];
            addr_q  <= bus.req_addr[int'(win_id)*ADDR_W +: ADDR_W];
            wdata_q <= bus.req_wdata[int'(win_id)*DATA_W +: DATA_W];
            xfer_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_GRANT: begin
          if (setup_seen) begin
            state_q <= ST_WAIT;
            xfer_q  <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (access_done) begin
            state_q <= ST_DONE;
            ack_q   <= ACK_ONE << grant_q;
            if (!rw_q) begin
              rdata_q <= bus.prdata;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
`ifdef APB_ARB_FIXED_PRI_EN
          ptr_q   <= '0;
`else
          ptr_q   <= ptr_d;
`endif
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          xfer_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ack          = ack_q;
  assign bus.rdata        = rdata_q;
  assign bus.grant_id     = grant_q;
  assign bus.busy         = busy_q;
  assign bus.m_transfer   = xfer_q;
  assign bus.m_read_write = rw_q;
  assign bus.m_addr       = addr_q;
  assign bus.m_wdata      = wdata_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter with a small APB master/slave
// model: single read/write, wait states, contention, fairness, reset.
module tb_apb_master_arbiter;

  logic clk;
  logic rst;

  apb_master_arbiter_if #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(8)) bus ();

  apb_master_arbiter #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum logic [1:0] {M_IDLE, M_SETUP, M_ACC} mst_e;
  mst_e       mst;
  int         wcnt;
  int         wait_cfg;
  logic [7:0] mem [256];

  always @(posedge clk) begin
    if (rst) begin
      mst         <= M_IDLE;
      bus.psel    <= 1'b0;
      bus.penable <= 1'b0;
      wcnt        <= 0;
      mem[8'h10]  <= 8'hA5;
      mem[8'h31]  <= 8'h5A;
      mem[8'h44]  <= 8'h77;
    end else begin
      case (mst)
        M_IDLE: begin
          if (bus.m_transfer) begin
            mst      <= M_SETUP;
            bus.psel <= 1'b1;
          end
        end
        M_SETUP: begin
          mst         <= M_ACC;
          bus.penable <= 1'b1;
          wcnt        <= wait_cfg;
        end
        M_ACC: begin
          if (bus.pready) begin
            if (bus.m_read_write) mem[bus.m_addr] <= bus.m_wdata;
            bus.penable <= 1'b0;
            if (bus.m_transfer) begin
              mst <= M_SETUP;
            end else begin
              mst      <= M_IDLE;
              bus.psel <= 1'b0;
            end
          end else begin
            wcnt <= wcnt - 1;
          end
        end
        default: mst <= M_IDLE;
      endcase
    end
  end

  assign bus.pready = (wcnt == 0);
  assign bus.prdata = mem[bus.m_addr];

  int n_chk;
  int n_fail;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic rw,
                         input logic [7:0] a, input logic [7:0] d);
    bus.req_rw[i]           = rw;
    bus.req_addr[i*8 +: 8]  = a;
    bus.req_wdata[i*8 +: 8] = d;
    bus.req[i]              = 1'b1;
  endtask

  task automatic wait_ack(input string tag, input logic [3:0] exp,
                          input int exp_cyc, input bit drop);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (bus.ack == 4'b0 && n < 40);
    chk({tag, "_ack"}, 32'(bus.ack), 32'(exp));
    chk({tag, "_lat"}, n, exp_cyc);
    if (drop) bus.req = bus.req & ~bus.ack;
  endtask

  initial begin
    n_chk         = 0;
    n_fail        = 0;
    wait_cfg      = 0;
    rst           = 1'b1;
    bus.req       = '0;
    bus.req_rw    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    step();
    step();
    chk("rst_ack",   32'(bus.ack), 0);
    chk("rst_rdata", 32'(bus.rdata), 0);
    chk("rst_gid",   32'(bus.grant_id), 0);
    chk("rst_busy",  32'(bus.busy), 0);
    chk("rst_xfer",  32'(bus.m_transfer), 0);
    chk("rst_rw",    32'(bus.m_read_write), 0);
    chk("rst_addr",  32'(bus.m_addr), 0);
    chk("rst_wdata", 32'(bus.m_wdata), 0);
    rst = 1'b0;
    step();

    // single read
    set_req(0, 1'b0, 8'h10, 8'h00);
    step();
    chk("rd_busy", 32'(bus.busy), 1);
    chk("rd_xfer", 32'(bus.m_transfer), 1);
    chk("rd_addr", 32'(bus.m_addr), 32'h10);
    chk("rd_rw",   32'(bus.m_read_write), 0);
    step();
    step();
    chk("rd_wait_xfer", 32'(bus.m_transfer), 0);
    chk("rd_wait_addr", 32'(bus.m_addr), 32'h10);
    chk("rd_wait_ack",  32'(bus.ack), 0);
    step();
    chk("rd_ack",   32'(bus.ack), 32'b0001);
    chk("rd_rdata", 32'(bus.rdata), 32'hA5);
    bus.req[0] = 1'b0;
    step();
    chk("rd_ack_off", 32'(bus.ack), 0);
    chk("rd_idle",    32'(bus.busy), 0);

    // single write
    set_req(2, 1'b1, 8'h22, 8'h3C);
    step();
    chk("wr_gid",   32'(bus.grant_id), 2);
    chk("wr_rw",    32'(bus.m_read_write), 1);
    chk("wr_addr",  32'(bus.m_addr), 32'h22);
    chk("wr_wdata", 32'(bus.m_wdata), 32'h3C);
    step();
    step();
    chk("wr_wait_wdata", 32'(bus.m_wdata), 32'h3C);
    wait_ack("wr", 4'b0100, 1, 1'b1);
    chk("wr_rdata", 32'(bus.rdata), 32'hA5);
    chk("wr_mem",   32'(mem[8'h22]), 32'h3C);
    step();

    // wait states
    wait_cfg = 3;
    set_req(1, 1'b0, 8'h31, 8'h00);
    step();
    chk("ws_gid", 32'(bus.grant_id), 1);
    step();
    step();
    for (int c = 0; c < 3; c++) begin
      chk("ws_ack",  32'(bus.ack), 0);
      chk("ws_xfer", 32'(bus.m_transfer), 0);
      chk("ws_addr", 32'(bus.m_addr), 32'h31);
      step();
    end
    chk("ws_ack_last", 32'(bus.ack), 0);
    wait_ack("ws", 4'b0010, 1, 1'b1);
    chk("ws_rdata", 32'(bus.rdata), 32'h5A);
    wait_cfg = 0;

    // contention, pointer restarted at 0
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 8'(8'h80 + i), 8'(i));
    wait_ack("ct0", 4'b0001, 4, 1'b1);
    wait_ack("ct1", 4'b0010, 5, 1'b1);
    wait_ack("ct2", 4'b0100, 5, 1'b1);
    wait_ack("ct3", 4'b1000, 5, 1'b1);
    bus.req = 4'b1111;
    wait_ack("cu0", 4'b0001, 5, 1'b1);
    wait_ack("cu1", 4'b0010, 5, 1'b1);
    wait_ack("cu2", 4'b0100, 5, 1'b1);
    wait_ack("cu3", 4'b1000, 5, 1'b1);
    step();

    // fairness: requester 3 held, requester 1 raised mid-transfer
    set_req(3, 1'b1, 8'h90, 8'h11);
    step();
    chk("fr_gid", 32'(bus.grant_id), 3);
    set_req(1, 1'b0, 8'h31, 8'h00);
    wait_ack("fr3", 4'b1000, 3, 1'b0);
    wait_ack("fr1", 4'b0010, 5, 1'b1);
    chk("fr_rdata", 32'(bus.rdata), 32'h5A);
    wait_ack("fr3b", 4'b1000, 5, 1'b1);
    step();

    // grant 1 leaves the pointer at 2
    set_req(1, 1'b0, 8'h10, 8'h00);
    wait_ack("pp", 4'b0010, 4, 1'b1);
    step();

    // reset mid-WAIT
    wait_cfg = 100;
    set_req(2, 1'b0, 8'h44, 8'h00);
    step();
    step();
    step();
    step();
    chk("rw_busy", 32'(bus.busy), 1);
    chk("rw_xfer", 32'(bus.m_transfer), 0);
    rst = 1'b1;
    step();
    chk("rw_rst_busy",  32'(bus.busy), 0);
    chk("rw_rst_ack",   32'(bus.ack), 0);
    chk("rw_rst_xfer",  32'(bus.m_transfer), 0);
    chk("rw_rst_gid",   32'(bus.grant_id), 0);
    chk("rw_rst_addr",  32'(bus.m_addr), 0);
    chk("rw_rst_rdata", 32'(bus.rdata), 0);
    wait_cfg = 0;
    rst = 1'b0;
    set_req(1, 1'b1, 8'h55, 8'h66);
    wait_ack("rr1", 4'b0010, 4, 1'b1);
    wait_ack("rr2", 4'b0100, 5, 1'b1);
    chk("rr_rdata", 32'(bus.rdata), 32'h77);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
